// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer
// Request front-end for the trojan6 memory host. Requests are buffered in a
// small FIFO and sent to the host one at a time. Each command is held for
// CMD_HOLD cycles. The block then waits for mem_ready and returns a one-cycle
// response. A watchdog answers with a timeout response if mem_ready never
// comes.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   req_valid    request offered; accepted when req_ready is also high
//   req_ready    FIFO not full
//   req_write    1 = write, 0 = read
//   req_addr     request address
//   req_wdata    write data
//   mem_addr     address to the host
//   write_data   write data to the host
//   mem_read     read command to the host
//   mem_write    write command to the host
//   mem_ready    host completion pulse
//   read_data    host read data
//   rsp_valid    one-cycle response pulse, no backpressure
//   rsp_write    response belongs to a write
//   rsp_rdata    read data (0 for writes and timeouts)
//   rsp_timeout  response came from the watchdog
//   busy         FSM not idle or FIFO not empty
module mem_req_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CMD_HOLD   = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  input  logic [31:0] read_data,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(CMD_HOLD) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [64:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic [1:0]    r_state;
  logic [HW-1:0] r_holdCnt;
  logic [TW-1:0] r_waitCnt;
  logic          r_curWrite;
  logic [31:0]   r_memAddr;
  logic [31:0]   r_writeData;
  logic          r_memRead;
  logic          r_memWrite;
  logic          r_rspValid;
  logic          r_rspWrite;
  logic [31:0]   r_rspRdata;
  logic          r_rspTimeout;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [64:0]   w_head;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  // This keeps req_ready a pure function of the count.
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = req_valid & ~w_full;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  assign w_head    = r_fifo[r_rdPtr];
  assign req_ready = ~w_full;

  // Storage is not reset. The pointers and the count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= {req_write, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Transaction FSM. The command drops at the end of ISSUE, before the host
  // can answer. mem_ready is only acted on in WAIT, so late or stale pulses
  // are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_holdCnt    <= '0;
      r_waitCnt    <= '0;
      r_curWrite   <= 1'b0;
      r_memAddr    <= '0;
      r_writeData  <= '0;
      r_memRead    <= 1'b0;
      r_memWrite   <= 1'b0;
      r_rspValid   <= 1'b0;
      r_rspWrite   <= 1'b0;
      r_rspRdata   <= '0;
      r_rspTimeout <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_curWrite  <= w_head[64];
            r_memAddr   <= w_head[63:32];
            r_writeData <= w_head[31:0];
            r_memRead   <= ~w_head[64];
            r_memWrite  <= w_head[64];
            r_holdCnt   <= HW'(CMD_HOLD - 1);
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_holdCnt == '0) begin
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_waitCnt  <= '0;
            r_state    <= S_WAIT;
          end else begin
            r_holdCnt <= r_holdCnt - 1'b1;
          end
        end
        S_WAIT: begin
          // If mem_ready arrives in the same cycle as the timeout, mem_ready wins.
          if (mem_ready) begin
            r_rspValid   <= 1'b1;
            r_rspWrite   <= r_curWrite;
            r_rspRdata   <= r_curWrite ? 32'd0 : read_data;
            r_rspTimeout <= 1'b0;
            r_state      <= S_RESP;
          end else if (r_waitCnt == TW'(TIMEOUT - 1)) begin
            r_rspValid   <= 1'b1;
            r_rspWrite   <= r_curWrite;
            r_rspRdata   <= '0;
            r_rspTimeout <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        default: begin
          r_rspWrite   <= 1'b0;
          r_rspRdata   <= '0;
          r_rspTimeout <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = r_memAddr;
  assign write_data  = r_writeData;
  assign mem_read    = r_memRead;
  assign mem_write   = r_memWrite;
  assign rsp_valid   = r_rspValid;
  assign rsp_write   = r_rspWrite;
  assign rsp_rdata   = r_rspRdata;
  assign rsp_timeout = r_rspTimeout;
  assign busy        = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb_mem_req_sequencer
// Directed bench for mem_req_sequencer.
// A small host model answers each command 2 cycles after the command drops.
// Expected responses are queued when a request is accepted. A monitor pops
// and compares them whenever rsp_valid is seen.
module tb_mem_req_sequencer;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
    logic        to;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready;
  logic [31:0] read_data;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;

  int   testsRun;
  int   testsFailed;
  exp_t expQ[$];

  logic        hostEnable;
  logic        hostReady;
  logic        staleReady;
  logic        prevCmd;
  int          hostDly;
  logic [31:0] hostMem [0:255];

  int cycleCnt;
  int lastRsp;
  int prevRsp;
  int holdRun;
  bit sawOverlap;

  assign mem_ready = hostReady | staleReady;

  mem_req_sequencer #(.FIFO_DEPTH(4), .CMD_HOLD(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_ready(mem_ready), .read_data(read_data),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Host model: applies writes and fetches read data when a command rises.
  // It pulses mem_ready so that WAIT lasts two cycles.
  always @(negedge clk) begin
    hostReady = 1'b0;
    if (!rst) begin
      hostDly = -1;
      prevCmd = 1'b0;
    end else begin
      if (hostDly > 0) begin
        hostDly = hostDly - 1;
        if (hostDly == 0) begin
          hostReady = 1'b1;
          hostDly   = -1;
        end
      end
      if (!prevCmd && mem_write) hostMem[mem_addr[7:0]] = write_data;
      if (!prevCmd && mem_read)  read_data = hostMem[mem_addr[7:0]];
      if (prevCmd && !(mem_read | mem_write) && hostEnable) hostDly = 1;
      prevCmd = mem_read | mem_write;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor. It also measures how long each command stays high.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      holdRun    = 0;
      sawOverlap = 1'b0;
    end else begin
      if (mem_read && mem_write) sawOverlap = 1'b1;
      if (mem_read || mem_write) begin
        holdRun++;
      end else if (holdRun > 0) begin
        checkOutput("cmd_hold_cycles", 32'(holdRun), 32'd3);
        checkOutput("cmd_overlap", {31'd0, sawOverlap}, 32'd0);
        holdRun    = 0;
        sawOverlap = 1'b0;
      end
      if (rsp_valid) begin
        prevRsp = lastRsp;
        lastRsp = cycleCnt;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_write", {31'd0, rsp_write}, {31'd0, e.w});
          checkOutput("rsp_rdata", rsp_rdata, e.d);
          checkOutput("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
        end
      end
    end
  end

  // Offers one request, waits (bounded) until it is accepted, and queues the
  // expected response. Returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] expData, input logic expTo);
    bit accepted;
    exp_t e;
    accepted = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      if (req_ready) begin
        e.w = w;
        e.d = expData;
        e.to = expTo;
        expQ.push_back(e);
        @(posedge clk);
        accepted = 1'b1;
        #1;
        req_valid = 1'b0;
      end
    end
    if (!accepted) begin
      req_valid = 1'b0;
      checkOutput("push_accept_timeout", 32'd0, 32'd1);
    end
  endtask

  // Counts rising edges from the push edge (counted as 1) until rsp_valid is seen.
  task automatic measureLatency(input string name, input int expected);
    int lat;
    bit seen;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) checkOutput({name, "_no_rsp"}, 32'd0, 32'd1);
    else       checkOutput(name, 32'(lat), 32'(expected));
  endtask

  task automatic waitIdle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (!busy && expQ.size() == 0) idle = 1'b1;
    end
    if (!idle) checkOutput({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    cycleCnt    = 0;
    lastRsp     = 0;
    prevRsp     = 0;
    holdRun     = 0;
    sawOverlap  = 1'b0;
    hostEnable  = 1'b1;
    hostReady   = 1'b0;
    staleReady  = 1'b0;
    prevCmd     = 1'b0;
    hostDly     = -1;
    read_data   = '0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    for (int i = 0; i < 256; i++) hostMem[i] = 32'h0;
    hostMem[8'h05] = 32'hFEDCBA9D;
    for (int i = 0; i < 6; i++) hostMem[8'h20 + i] = 32'hA0A0_0000 + 32'(i);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("reset_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single read
    applyStimulus(1'b0, 32'h5, 32'h0, 32'hFEDCBA9D, 1'b0);
    measureLatency("read_latency", 7);
    waitIdle("single_read");

    // Write then read back the same address, back to back
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    waitIdle("write_read");
    checkOutput("b2b_spacing", 32'(lastRsp - prevRsp), 32'd7);

    // FIFO full: five back-to-back pushes fit because one pops at once
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 32'h20 + 32'(i), 32'h0, 32'hA0A0_0000 + 32'(i), 1'b0);
    @(negedge clk);
    checkOutput("full_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("full_busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 32'h25, 32'h0, 32'hA0A0_0005, 1'b0);
    waitIdle("fifo_full");

    // Timeout: the host never answers
    hostEnable = 1'b0;
    applyStimulus(1'b0, 32'h5, 32'h0, 32'h0, 1'b1);
    measureLatency("timeout_latency", 21);
    waitIdle("timeout");
    hostEnable = 1'b1;
    applyStimulus(1'b0, 32'h5, 32'h0, 32'hFEDCBA9D, 1'b0);
    waitIdle("after_timeout");

    // Reset in the middle of ISSUE
    applyStimulus(1'b0, 32'h20, 32'h0, 32'hA0A0_0000, 1'b0);
    for (int i = 0; i < 20 && !mem_read; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_mem_read", {31'd0, mem_read}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset_mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("midreset_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    // Stale mem_ready while idle with an empty FIFO
    staleReady = 1'b1;
    @(negedge clk);
    staleReady = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("stale_busy", {31'd0, busy}, 32'd0);
    checkOutput("stale_mem_read", {31'd0, mem_read}, 32'd0);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
